// File: rtl/motoro3_pkg.sv
// Shared constants, state encoding and helpers for the motoro3 PWM generator.
// Widths match the register file fields that feed this stage.
package motoro3_pkg;

  localparam int STEP_NUM = 6;
  localparam int CNT_W    = 25;
  localparam int PWM_W    = 12;
  localparam int STEP_W   = 4;
  localparam int SPLIT_W  = 2;
  localparam int POS_W    = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Duty never exceeds the period it is applied to.
  function automatic logic [PWM_W-1:0] clamp_duty(input logic [PWM_W-1:0] duty,
                                                  input logic [PWM_W-1:0] per);
    return (duty > per) ? per : duty;
  endfunction

endpackage

// File: rtl/motoro3_pwm_gen_if.sv
// Configuration, calculator feedback and timing outputs of the PWM generator.
// No handshake: inputs are sampled every clk; outputs are valid every clk, strobes are one-cycle pulses.
interface motoro3_pwm_gen_if;
  import motoro3_pkg::*;

  logic                m3r_run;
  logic [CNT_W-1:0]    m3r_stepCNT_speedSET;
  logic [SPLIT_W-1:0]  m3r_stepSplitMax;
  logic [PWM_W-1:0]    m3r_pwmLenWant;
  logic [POS_W-1:0]    pwmLENpos;
  logic [STEP_W-1:0]   lcStep;
  logic [SPLIT_W-1:0]  m3LpwmSplitStep;
  logic                pwmOut;
  logic                stepEndP;
  logic                periodStartP;
  state_t              dbg_state;

  modport master (
    output m3r_run, m3r_stepCNT_speedSET, m3r_stepSplitMax, m3r_pwmLenWant, pwmLENpos,
    input  lcStep, m3LpwmSplitStep, pwmOut, stepEndP, periodStartP, dbg_state
  );

  modport slave (
    input  m3r_run, m3r_stepCNT_speedSET, m3r_stepSplitMax, m3r_pwmLenWant, pwmLENpos,
    output lcStep, m3LpwmSplitStep, pwmOut, stepEndP, periodStartP, dbg_state
  );

endinterface

// File: rtl/motoro3_pwm_cnt.sv
// PWM period counter, period-boundary duty latch and registered comparator.
// Period and duty are sampled only when the counter is at 0, so edges never glitch mid-period.
module motoro3_pwm_cnt
  import motoro3_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [PWM_W-1:0] perIn,
  input  logic [PWM_W-1:0] dutyIn,
  output logic             pwmOut,
  output logic             periodStartP
);

  localparam logic [PWM_W-1:0] PWM_ONE = 1;

  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0] per_l_q, per_l_d;
  logic [PWM_W-1:0] duty_l_q, duty_l_d;
  logic             pwm_out_q, pwm_out_d;
  logic [PWM_W-1:0] per_eff;
  logic [PWM_W-1:0] duty_eff;
  logic             at_start;

  always_comb begin
    at_start     = (pwm_cnt_q == '0);
    per_eff      = at_start ? perIn : per_l_q;
    duty_eff     = at_start ? clamp_duty(dutyIn, perIn) : duty_l_q;
    pwm_cnt_d    = '0;
    per_l_d      = per_l_q;
    duty_l_d     = duty_l_q;
    pwm_out_d    = 1'b0;
    periodStartP = run && at_start;
    if (run) begin
      per_l_d   = per_eff;
      duty_l_d  = duty_eff;
      pwm_out_d = (per_eff != '0) && (pwm_cnt_q < duty_eff);
      // A zero period parks the counter at 0 so the next sample is immediate.
      if ((per_eff != '0) && (pwm_cnt_q != per_eff - PWM_ONE)) begin
        pwm_cnt_d = pwm_cnt_q + PWM_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      per_l_q   <= '0;
      duty_l_q  <= '0;
      pwm_out_q <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      per_l_q   <= per_l_d;
      duty_l_q  <= duty_l_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  assign pwmOut = pwm_out_q;

endmodule

// File: rtl/motoro3_pwm_gen.sv
// Commutation step / split sub-step sequencer with the PWM counter underneath.
// Step and split are registered; the downstream calculator answers combinationally.
module motoro3_pwm_gen
  import motoro3_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  motoro3_pwm_gen_if.slave   bus
);

  localparam logic [CNT_W-1:0]   CNT_ONE   = 1;
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_NUM - 1);
  localparam logic [STEP_W-1:0]  STEP_ONE  = 1;
  localparam logic [SPLIT_W-1:0] SPLIT_ONE = 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    sub_cnt_q, sub_cnt_d;
  logic [CNT_W-1:0]    spd_l_q, spd_l_d;
  logic [SPLIT_W-1:0]  split_q, split_d;
  logic [STEP_W-1:0]   lc_step_q, lc_step_d;
  logic [CNT_W-1:0]    spd_eff;
  logic                running;
  logic                sub_end;
  logic                step_end;
  logic                pos_unused;

  always_comb begin
    running  = (state_q == S_RUN);
    spd_eff  = (sub_cnt_q == '0) ? bus.m3r_stepCNT_speedSET : spd_l_q;
    sub_end  = running && (spd_eff != '0) && (sub_cnt_q == spd_eff - CNT_ONE);
    // >= so a split max lowered below the current split ends the step cleanly.
    step_end = sub_end && (split_q >= bus.m3r_stepSplitMax);

    state_d   = state_q;
    sub_cnt_d = '0;
    split_d   = '0;
    lc_step_d = lc_step_q;
    spd_l_d   = spd_l_q;

    case (state_q)
      S_IDLE: begin
        if (bus.m3r_run) state_d = S_RUN;
      end
      S_RUN: begin
        spd_l_d   = spd_eff;
        sub_cnt_d = sub_cnt_q;
        split_d   = split_q;
        if (spd_eff != '0) begin
          if (sub_end) begin
            sub_cnt_d = '0;
            if (step_end) begin
              split_d   = '0;
              lc_step_d = (lc_step_q == STEP_LAST) ? '0 : lc_step_q + STEP_ONE;
            end else begin
              split_d = split_q + SPLIT_ONE;
            end
          end else begin
            sub_cnt_d = sub_cnt_q + CNT_ONE;
          end
        end
        if (!bus.m3r_run) begin
          state_d   = S_IDLE;
          sub_cnt_d = '0;
          split_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sub_cnt_q <= '0;
      spd_l_q   <= '0;
      split_q   <= '0;
      lc_step_q <= '0;
    end else begin
      state_q   <= state_d;
      sub_cnt_q <= sub_cnt_d;
      spd_l_q   <= spd_l_d;
      split_q   <= split_d;
      lc_step_q <= lc_step_d;
    end
  end

  motoro3_pwm_cnt u_pwm_cnt (
    .clk          (clk),
    .rst          (rst),
    .run          (running),
    .perIn        (bus.m3r_pwmLenWant),
    .dutyIn       (bus.pwmLENpos[PWM_W-1:0]),
    .pwmOut       (bus.pwmOut),
    .periodStartP (bus.periodStartP)
  );

  assign pos_unused          = ^bus.pwmLENpos[POS_W-1:PWM_W];
  assign bus.lcStep          = lc_step_q;
  assign bus.m3LpwmSplitStep = split_q;
  assign bus.stepEndP        = step_end;
  assign bus.dbg_state       = state_q;

endmodule

// File: tb/tb_motoro3_pwm_gen.sv
// Bench for motoro3_pwm_gen: cycle reference model feeds an expected queue, a negedge monitor compares.
// Directed windows also count pulses and high cycles against hand-derived totals.
module tb_motoro3_pwm_gen;
  import motoro3_pkg::*;

  localparam int EW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  motoro3_pwm_gen_if bus ();

  motoro3_pwm_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int hi_cnt = 0, se_cnt = 0, ps_cnt = 0;
  int w_hi = -1, w_se = -1, w_ps = -1;

  // Reference model: position in step, split, step, PWM phase and latched values.
  int m_run, m_sub, m_split, m_step, m_spd, m_pcnt, m_per, m_duty, m_pout;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] exp_v, act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {bus.dbg_state == S_RUN, bus.lcStep, bus.m3LpwmSplitStep,
               bus.pwmOut, bus.stepEndP, bus.periodStartP};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t got run/step/split/pwm/se/ps=%b want %b", $time, act_v, exp_v);
      end
      hi_cnt += int'(bus.pwmOut);
      se_cnt += int'(bus.stepEndP);
      ps_cnt += int'(bus.periodStartP);
    end
  end

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_sub = 0; m_split = 0; m_step = 0; m_spd = 0;
    m_pcnt = 0; m_per = 0; m_duty = 0; m_pout = 0;
  endtask

  // Called at posedge+1 with inputs already applied for this cycle.
  task automatic tick(input bit chk);
    int spd_in, smax, per_in, pos_in, spd, per, duty, se, ps;
    spd_in = int'(bus.m3r_stepCNT_speedSET);
    smax   = int'(bus.m3r_stepSplitMax);
    per_in = int'(bus.m3r_pwmLenWant);
    pos_in = int'(bus.pwmLENpos) % 4096;
    spd    = (m_sub == 0) ? spd_in : m_spd;
    se     = (m_run == 1 && spd > 0 && m_sub == spd - 1 && m_split >= smax) ? 1 : 0;
    ps     = (m_run == 1 && m_pcnt == 0) ? 1 : 0;
    exp_q.push_back({m_run[0], 4'(m_step), 2'(m_split), m_pout[0], se[0], ps[0]});

    if (rst) begin
      model_reset();
    end else if (m_run == 0) begin
      m_sub = 0; m_split = 0; m_pcnt = 0; m_pout = 0;
      m_run = int'(bus.m3r_run);
    end else begin
      m_spd = spd;
      if (spd > 0) begin
        if (m_sub == spd - 1) begin
          m_sub = 0;
          if (m_split < smax) m_split++;
          else begin
            m_split = 0;
            m_step  = (m_step + 1) % STEP_NUM;
          end
        end else m_sub++;
      end
      per  = (m_pcnt == 0) ? per_in : m_per;
      duty = (m_pcnt == 0) ? ((pos_in < per_in) ? pos_in : per_in) : m_duty;
      m_per  = per;
      m_duty = duty;
      m_pout = (per > 0 && m_pcnt < duty) ? 1 : 0;
      m_pcnt = (per == 0) ? 0 : (m_pcnt + 1) % per;
      if (!bus.m3r_run) begin
        m_run = 0; m_sub = 0; m_split = 0;
      end
    end

    @(negedge clk);
    #1;
    if (chk) begin
      if (w_hi >= 0) check_int("pwm_high_count", hi_cnt, w_hi);
      if (w_se >= 0) check_int("step_end_count", se_cnt, w_se);
      if (w_ps >= 0) check_int("period_start_count", ps_cnt, w_ps);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input int n, input int e_hi, input int e_se, input int e_ps);
    hi_cnt = 0; se_cnt = 0; ps_cnt = 0;
    w_hi = e_hi; w_se = e_se; w_ps = e_ps;
    for (int i = 0; i < n - 1; i++) tick(1'b0);
    tick(1'b1);
  endtask

  task automatic wait_expired(input string name, input int g, input int limit);
    checks++;
    if (g >= limit) begin
      errors++;
      $display("FAIL %s wait budget %0d used %0d", name, limit, g);
    end
  endtask

  initial begin
    int g;
    rst = 1'b1;
    bus.m3r_run = 1'b0;
    bus.m3r_stepCNT_speedSET = '0;
    bus.m3r_stepSplitMax = '0;
    bus.m3r_pwmLenWant = '0;
    bus.pwmLENpos = '0;
    @(posedge clk);
    #1;
    model_reset();
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0;
    repeat (3) tick(1'b0);

    // Basic sequencing and PWM shape: 1 idle cycle then 48 run cycles.
    bus.m3r_stepCNT_speedSET = 25'd4;
    bus.m3r_stepSplitMax = 2'd1;
    bus.m3r_pwmLenWant = 12'd10;
    bus.pwmLENpos = 16'd3;
    bus.m3r_run = 1'b1;
    run_window(49, 15, 6, 5);
    check_int("lc_step_wrapped", int'(bus.lcStep), 0);

    // Duty change mid-period takes effect from the next period.
    g = 0;
    while (m_pcnt != 5 && g < 20) begin tick(1'b0); g++; end
    wait_expired("pwm_cnt_5", g, 20);
    bus.pwmLENpos = 16'd7;
    g = 0;
    while (m_pcnt != 0 && g < 20) begin tick(1'b0); g++; end
    wait_expired("period_boundary", g, 20);
    run_window(10, 7, -1, 1);

    // Duty boundaries.
    bus.pwmLENpos = 16'd0;
    repeat (12) tick(1'b0);
    run_window(20, 0, -1, 2);
    bus.pwmLENpos = 16'h0FFF;
    repeat (12) tick(1'b0);
    run_window(20, 20, -1, 2);
    bus.pwmLENpos = 16'hF002;
    repeat (12) tick(1'b0);
    run_window(20, 4, -1, 2);
    bus.m3r_pwmLenWant = 12'd0;
    repeat (12) tick(1'b0);
    run_window(20, 0, -1, 20);

    // Stop at step 3 / split 1, restart, then reset while running.
    bus.m3r_pwmLenWant = 12'd10;
    bus.pwmLENpos = 16'd3;
    g = 0;
    while (!(m_step == 3 && m_split == 1 && m_sub == 1) && g < 400) begin tick(1'b0); g++; end
    wait_expired("step3_split1", g, 400);
    bus.m3r_run = 1'b0;
    repeat (3) tick(1'b0);
    check_int("stopped_step", int'(bus.lcStep), 3);
    check_int("stopped_split", int'(bus.m3LpwmSplitStep), 0);
    bus.m3r_run = 1'b1;
    run_window(9, -1, 1, -1);
    check_int("restart_step", int'(bus.lcStep), 4);
    repeat (5) tick(1'b0);
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    check_int("reset_step", int'(bus.lcStep), 0);
    tick(1'b0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.m3r_run = ($urandom_range(0, 63) != 0);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) bus.m3r_stepCNT_speedSET = 25'($urandom_range(0, 5));
      if ($urandom_range(0, 31) == 0) bus.m3r_stepSplitMax = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) bus.m3r_pwmLenWant = 12'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0)
        bus.pwmLENpos = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 14));
      tick(1'b0);
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
